// File: rtl/mod12_counter_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mod12_seq_pkg
// Shared types and constants for the mod-12 counter command sequencer.
//   op_e      : command opcodes carried on req_op (2 bits per requester)
//   state_e   : sequencer FSM states
//   MOD_MAX   : largest legal counter value (counter wraps 11 <-> 0)
//   load_arg_ok / needs_run : command classification helpers
// -----------------------------------------------------------------------------
package mod12_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [3:0] MOD_MAX = 4'd11;

  // A LOAD value is only accepted if the counter can actually hold it.
  function automatic logic load_arg_ok(input logic [3:0] arg);
    return (arg <= MOD_MAX);
  endfunction

  // Commands that touch the counter need at least one RUN cycle; READ,
  // zero-step moves and rejected LOADs go straight to the response.
  function automatic logic needs_run(input op_e op, input logic [3:0] arg);
    logic run;
    case (op)
      OP_LOAD: run = load_arg_ok(arg);
      OP_UP,
      OP_DOWN: run = (arg != 4'd0);
      default: run = 1'b0;
    endcase
    return run;
  endfunction

endpackage

// File: rtl/mod12_counter_sequencer_if.sv
// -----------------------------------------------------------------------------
// mod12_counter_sequencer_if
// Requester-side command bus and response channel of the sequencer.
//   req_valid  [NREQ]    per-requester command valid
//   req_op     [2*NREQ]  per-requester opcode (op_e encoding)
//   req_arg    [4*NREQ]  per-requester argument
//   req_ready  [NREQ]    one-hot accept from the sequencer
//   resp_valid           one-cycle completion pulse
//   resp_id    [ID_W]    requester index of the completed command
//   resp_value [4]       counter value at completion
//   resp_err             LOAD value out of range, counter untouched
// master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface mod12_counter_sequencer_if #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
);

  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_op;
  logic [4*NREQ-1:0] req_arg;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [ID_W-1:0]   resp_id;
  logic [3:0]        resp_value;
  logic              resp_err;

  modport master (
    output req_valid,
    output req_op,
    output req_arg,
    input  req_ready,
    input  resp_valid,
    input  resp_id,
    input  resp_value,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_arg,
    output req_ready,
    output resp_valid,
    output resp_id,
    output resp_value,
    output resp_err
  );

endinterface

// File: rtl/mod12_counter_sequencer_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant for NREQ requesters. The grant is combinational: the
// first valid requester at or after the priority pointer wins. The pointer
// moves to (winner + 1) mod NREQ only when the grant is actually taken.
//   clk, rst     clock, synchronous active-high reset (pointer -> 0)
//   en_i         grants allowed this cycle (sequencer idle)
//   req_i        per-requester valid
//   adv_i        grant accepted this cycle, advance the pointer
//   gnt_o        one-hot grant
//   gnt_id_o     index of the granted requester
//   gnt_any_o    some requester is granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_any_o
);

  // One extra bit so the wrap compare against NREQ cannot overflow.
  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NREQ);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W:0]   idx_s;
  logic [ID_W:0]   nxt_s;
  logic            found_s;

  // Search from the pointer upward, wrapping, and grant the first valid one.
  always_comb begin
    gnt_o    = {NREQ{1'b0}};
    gnt_id_o = {ID_W{1'b0}};
    found_s  = 1'b0;
    idx_s    = {(ID_W+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (idx_s >= NREQ_W) begin
        idx_s = idx_s - NREQ_W;
      end else begin
        idx_s = idx_s;
      end
      if (en_i && !found_s && req_i[idx_s[ID_W-1:0]]) begin
        gnt_o[idx_s[ID_W-1:0]] = 1'b1;
        gnt_id_o               = idx_s[ID_W-1:0];
        found_s                = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    gnt_any_o = found_s;
  end

  // Next pointer: one past the winner, wrapping at NREQ.
  always_comb begin
    nxt_s = {1'b0, gnt_id_o} + {{ID_W{1'b0}}, 1'b1};
    if (nxt_s == NREQ_W) begin
      nxt_s = {(ID_W+1){1'b0}};
    end else begin
      nxt_s = nxt_s;
    end
    if (adv_i) begin
      ptr_d = nxt_s[ID_W-1:0];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= {ID_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mod12_counter_sequencer.sv
// -----------------------------------------------------------------------------
// mod12_counter_sequencer
// Arbitrates LOAD/UP/DOWN/READ commands from NREQ requesters and drives the
// pins of an external loadable up/down mod-12 counter, one command at a time.
// The counter has no enable, so whenever the sequencer is not actively
// loading or stepping it reloads the counter with its own current value.
//   clk, rst     clock, synchronous active-high reset
//   bus          command/response bus (slave side), see the interface file
//   cnt_load     counter load pin
//   cnt_mode     counter direction (1 up, 0 down), only meaningful when !load
//   cnt_data_in  counter parallel load data
//   cnt_value    counter output
// Flow: IDLE (grant + latch) -> RUN (load or step arg times) -> DONE (resp).
// -----------------------------------------------------------------------------
module mod12_counter_sequencer
  import mod12_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  mod12_counter_sequencer_if.slave   bus,
  output logic                       cnt_load,
  output logic                       cnt_mode,
  output logic [3:0]                 cnt_data_in,
  input  logic [3:0]                 cnt_value
);

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [3:0]      arg_q, arg_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      step_q, step_d;

  logic [NREQ-1:0] gnt_s;
  logic [ID_W-1:0] gnt_id_s;
  logic            gnt_any_s;
  op_e             sel_op_s;
  logic [3:0]      sel_arg_s;

  logic            resp_valid_s;
  logic [ID_W-1:0] resp_id_s;
  logic [3:0]      resp_value_s;
  logic            resp_err_s;

  // Grants are only offered in IDLE; any grant is a handshake because the
  // arbiter never selects a requester whose valid is low.
  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == ST_IDLE),
    .req_i     (bus.req_valid),
    .adv_i     (gnt_any_s),
    .gnt_o     (gnt_s),
    .gnt_id_o  (gnt_id_s),
    .gnt_any_o (gnt_any_s)
  );

  assign bus.req_ready = gnt_s;

  // Pick the granted requester's command out of the flattened buses.
  assign sel_op_s  = op_e'(bus.req_op[{gnt_id_s, 1'b0} +: 2]);
  assign sel_arg_s = bus.req_arg[{gnt_id_s, 2'b00} +: 4];

  // FSM next state, command latches, counter pins and response.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    id_d         = id_q;
    step_d       = step_q;
    // Holding the count means reloading what the counter already shows.
    cnt_load     = 1'b1;
    cnt_mode     = 1'b0;
    cnt_data_in  = cnt_value;
    resp_valid_s = 1'b0;
    resp_id_s    = {ID_W{1'b0}};
    resp_value_s = 4'd0;
    resp_err_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any_s) begin
          op_d   = sel_op_s;
          arg_d  = sel_arg_s;
          id_d   = gnt_id_s;
          step_d = sel_arg_s;
          if (needs_run(sel_op_s, sel_arg_s)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        case (op_q)
          OP_LOAD: begin
            cnt_data_in = arg_q;
            state_d     = ST_DONE;
          end
          OP_UP,
          OP_DOWN: begin
            // The counter does its own wrap; we only count the steps.
            cnt_load = 1'b0;
            cnt_mode = (op_q == OP_UP);
            step_d   = step_q - 4'd1;
            if (step_q == 4'd1) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end
          default: begin
            state_d = ST_DONE;
          end
        endcase
      end

      ST_DONE: begin
        resp_valid_s = 1'b1;
        resp_id_s    = id_q;
        resp_value_s = cnt_value;
        resp_err_s   = (op_q == OP_LOAD) && !load_arg_ok(arg_q);
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.resp_valid = resp_valid_s;
  assign bus.resp_id    = resp_id_s;
  assign bus.resp_value = resp_value_s;
  assign bus.resp_err   = resp_err_s;

  // State and command registers; reset aborts any command without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      arg_q   <= 4'd0;
      id_q    <= {ID_W{1'b0}};
      step_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      id_q    <= id_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_mod12_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mod12_counter_sequencer
// Drives requester commands, models the external mod-12 counter, predicts
// each response with plain modular arithmetic and a round-robin grant model,
// and checks responses in a separate monitor through an expectation queue.
// -----------------------------------------------------------------------------
module tb_mod12_counter_sequencer;

  localparam int NREQ = 2;
  localparam int ID_W = 1;
  localparam int OPL = 0;
  localparam int OPU = 1;
  localparam int OPD = 2;
  localparam int OPR = 3;

  typedef struct {
    int id;
    int op;
    int arg;
    int value;
    int err;
    int lat;
    int lows;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod12_counter_sequencer_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  logic       cnt_load;
  logic       cnt_mode;
  logic [3:0] cnt_data_in;
  logic [3:0] cnt_value;
  logic [3:0] cnt_q;

  logic [NREQ-1:0]   pv;
  logic [2*NREQ-1:0] pop;
  logic [4*NREQ-1:0] parg;

  assign bus.req_valid = pv;
  assign bus.req_op    = pop;
  assign bus.req_arg   = parg;

  mod12_counter_sequencer #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cnt_load    (cnt_load),
    .cnt_mode    (cnt_mode),
    .cnt_data_in (cnt_data_in),
    .cnt_value   (cnt_value)
  );

  // External counter: loadable, wraps 11->0 up and 0->11 down.
  always @(posedge clk) begin
    if (rst)            cnt_q <= 4'd0;
    else if (cnt_load)  cnt_q <= cnt_data_in;
    else if (cnt_mode)  cnt_q <= (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
    else                cnt_q <= (cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1;
  end
  assign cnt_value = cnt_q;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ref_cnt;
  int   ptr_m;
  int   busy_left;
  bit   auto_mode;
  bit   keep_mode;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference behaviour of one accepted command.
  task automatic predict_push(input int id, input int op, input int arg);
    exp_t e;
    e.id = id; e.op = op; e.arg = arg; e.err = 0; e.lows = 0;
    case (op)
      OPL: begin
        if (arg > 11) begin
          e.err = 1; e.value = ref_cnt; e.lat = 1;
        end else begin
          ref_cnt = arg; e.value = arg; e.lat = 2;
        end
      end
      OPU: begin
        ref_cnt = (ref_cnt + arg) % 12;
        e.value = ref_cnt; e.lows = arg; e.lat = (arg == 0) ? 1 : arg + 1;
      end
      OPD: begin
        ref_cnt = (ref_cnt + 24 - arg) % 12;
        e.value = ref_cnt; e.lows = arg; e.lat = (arg == 0) ? 1 : arg + 1;
      end
      default: begin
        e.value = ref_cnt; e.lat = 1;
      end
    endcase
    busy_left = e.lat;
    exp_q.push_back(e);
  endtask

  task automatic new_cmd(input int i);
    int op;
    int arg;
    op  = $urandom_range(0, 3);
    arg = $urandom_range(0, 15);
    if (op == OPL && $urandom_range(0, 3) != 0) arg = $urandom_range(0, 11);
    pv[i] = 1'b1;
    pop[2*i +: 2]  = 2'(op);
    parg[4*i +: 4] = 4'(arg);
  endtask

  // One clock: check the grant against the model, predict, then update inputs.
  task automatic cycle();
    int hs_id;
    int exp_ready;
    @(negedge clk);
    hs_id = -1;
    exp_ready = 0;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (ptr_m + k) % NREQ;
        if (hs_id < 0 && pv[idx]) hs_id = idx;
      end
    end
    if (hs_id >= 0) exp_ready = 1 << hs_id;
    chk("req_ready", int'(bus.req_ready), exp_ready);
    if (hs_id >= 0) begin
      predict_push(hs_id, int'(pop[2*hs_id +: 2]), int'(parg[4*hs_id +: 4]));
      ptr_m = (hs_id + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    if (hs_id >= 0 && !keep_mode) pv[hs_id] = 1'b0;
    if (auto_mode) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 0) new_cmd(i);
      end
    end
  endtask

  task automatic issue(input int id, input int op, input int arg);
    pv[id] = 1'b1;
    pop[2*id +: 2]  = 2'(op);
    parg[4*id +: 4] = 4'(arg);
    for (int t = 0; t < 40 && pv[id]; t++) cycle();
    if (pv[id]) begin
      chk("grant_timeout", 0, 1);
      pv[id] = 1'b0;
    end
    while (busy_left > 0) cycle();
  endtask

  // Monitor: timing of the command in flight, pin checks and response compare.
  initial begin : monitor
    exp_t e;
    int   lat;
    int   lows;
    bit   act;
    act = 1'b0; lat = 0; lows = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act = 1'b0; lat = 0; lows = 0;
      end else begin
        if (act) begin
          lat++;
          if (!cnt_load) lows++;
        end
        if (cnt_load) chk("load_data_range", int'(cnt_data_in > 4'd11), 0);
        if (act && exp_q.size() > 0) begin
          e = exp_q[0];
          if (e.op == OPL && e.err == 0 && lat == 1) begin
            chk("load_pin", int'(cnt_load), 1);
            chk("load_data", int'(cnt_data_in), e.arg);
          end
          if ((e.op == OPU || e.op == OPD) && lat >= 1 && lat <= e.lows)
            chk("cnt_mode", int'(cnt_mode), (e.op == OPU) ? 1 : 0);
        end
        if (bus.resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_id", int'(bus.resp_id), e.id);
            chk("resp_value", int'(bus.resp_value), e.value);
            chk("resp_err", int'(bus.resp_err), e.err);
            chk("resp_latency", lat, e.lat);
            chk("step_cycles", lows, e.lows);
          end
          act = 1'b0;
        end
        if (|(bus.req_valid & bus.req_ready)) begin
          act = 1'b1; lat = 0; lows = 0;
        end
      end
    end
  end

  initial begin : main
    pv = '0; pop = '0; parg = '0;
    ref_cnt = 0; ptr_m = 0; busy_left = 0;
    auto_mode = 1'b0; keep_mode = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_resp_valid", int'(bus.resp_valid), 0);
    chk("reset_resp_id", int'(bus.resp_id), 0);
    chk("reset_resp_value", int'(bus.resp_value), 0);
    chk("reset_resp_err", int'(bus.resp_err), 0);
    chk("reset_ready", int'(bus.req_ready), 0);
    chk("reset_cnt_load", int'(cnt_load), 1);
    chk("reset_cnt_value", int'(cnt_value), 0);
    @(posedge clk);
    #1;

    // LOAD 7 from requester 0.
    issue(0, OPL, 7);
    // LOAD 9 then UP 5 wraps through 11 -> 0.
    issue(0, OPL, 9);
    issue(0, OPU, 5);
    // LOAD 1 then DOWN 3 wraps through 0 -> 11, then the count holds.
    issue(0, OPL, 1);
    issue(0, OPD, 3);
    repeat (10) begin
      cycle();
      chk("hold_value", int'(cnt_value), ref_cnt);
      chk("hold_load", int'(cnt_load), 1);
    end

    // Both requesters issuing READ back to back must alternate.
    keep_mode = 1'b1;
    pv = '1;
    pop = {2'(OPR), 2'(OPR)};
    repeat (16) cycle();
    keep_mode = 1'b0;
    pv = '0;
    while (busy_left > 0) cycle();
    cycle();

    // Out-of-range LOAD is rejected and leaves the count alone.
    issue(1, OPL, 13);
    issue(1, OPL, 15);
    issue(0, OPR, 0);

    // Reset in the third step of UP 10 drops the command silently.
    pv[0] = 1'b1;
    pop[1:0]  = 2'(OPU);
    parg[3:0] = 4'd10;
    for (int t = 0; t < 20 && pv[0]; t++) cycle();
    cycle();
    cycle();
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    busy_left = 0; ptr_m = 0; ref_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    issue(1, OPR, 0);
    issue(0, OPU, 3);
    issue(1, OPD, 0);

    // Random traffic on all requesters.
    auto_mode = 1'b1;
    repeat (1500) cycle();
    auto_mode = 1'b0;
    for (int t = 0; t < 300 && (pv != '0 || busy_left > 0); t++) cycle();
    cycle();
    cycle();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
